// File: rtl/mem_arbiter.sv
// Owner of the shared 8-bit RAM/IO port: ROB stores > LSB loads > IF fetches.
// Each access is serialised into byte cycles; reads are abandoned on flush.
module mem_arbiter #(
   parameter int unsigned       ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              lsb_req,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [1:0]        lsb_size,
   output logic              lsb_done,
   output logic [31:0]       lsb_data,
   input  logic              rob_req,
   input  logic [ADDR_W-1:0] rob_addr,
   input  logic [1:0]        rob_size,
   input  logic [31:0]       rob_data,
   output logic              rob_done,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
   typedef enum logic [1:0] {OWN_IF, OWN_LSB, OWN_ROB} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [2:0]        cnt_q, cnt_d, cnt_inc;
   logic [2:0]        nbytes_q, nbytes_d;
   logic [31:0]       rbuf_q, rbuf_d, rd_word;
   logic [23:0]       wbuf_q, wbuf_d;
   logic [1:0]        byte_idx;
   logic              rob_stall;
   logic [ADDR_W-1:0] mem_a_d;
   logic [7:0]        mem_dout_d;
   logic              mem_wr_d, if_done_d, lsb_done_d, rob_done_d;
   logic [31:0]       if_data_d, lsb_data_d;

   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      case (size)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign rob_stall = io_buffer_full && (rob_addr >= IO_BASE);
   assign cnt_inc   = cnt_q + 3'd1;
   // In READ the counter runs one ahead of the byte arriving on mem_din.
   assign byte_idx  = cnt_q[1:0] - 2'd1;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      nbytes_d   = nbytes_q;
      rbuf_d     = rbuf_q;
      wbuf_d     = wbuf_q;
      mem_a_d    = mem_a;
      mem_dout_d = mem_dout;
      mem_wr_d   = mem_wr;
      if_data_d  = if_data;
      lsb_data_d = lsb_data;
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      rob_done_d = 1'b0;
      rd_word    = rbuf_q;
      rd_word[{byte_idx, 3'b000} +: 8] = mem_din;

      case (state_q)
         S_IDLE: begin
            if (rob_req) begin
               if (!rob_stall) begin
                  state_d    = S_WRITE;
                  owner_d    = OWN_ROB;
                  cnt_d      = '0;
                  nbytes_d   = size_to_bytes(rob_size);
                  mem_a_d    = rob_addr;
                  mem_dout_d = rob_data[7:0];
                  wbuf_d     = rob_data[31:8];
                  mem_wr_d   = 1'b1;
               end
            end else if (!flush && (lsb_req || if_req)) begin
               state_d  = S_READ;
               owner_d  = lsb_req ? OWN_LSB : OWN_IF;
               cnt_d    = '0;
               nbytes_d = lsb_req ? size_to_bytes(lsb_size) : 3'd4;
               mem_a_d  = lsb_req ? lsb_addr : if_addr;
               mem_wr_d = 1'b0;
               rbuf_d   = '0;
            end
         end
         S_READ: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               mem_a_d = '0;
            end else begin
               if (cnt_q != 3'd0) rbuf_d = rd_word;
               mem_a_d = (cnt_inc < nbytes_q) ? mem_a + ADDR_W'(1) : '0;
               if (cnt_q == nbytes_q) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  if (owner_q == OWN_IF) begin
                     if_done_d = 1'b1;
                     if_data_d = rd_word;
                  end else begin
                     lsb_done_d = 1'b1;
                     lsb_data_d = rd_word;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_WRITE: begin
            if (cnt_inc < nbytes_q) begin
               cnt_d      = cnt_inc;
               mem_a_d    = mem_a + ADDR_W'(1);
               mem_dout_d = wbuf_q[7:0];
               wbuf_d     = wbuf_q >> 8;
            end else begin
               state_d    = S_IDLE;
               cnt_d      = '0;
               mem_a_d    = '0;
               mem_dout_d = '0;
               mem_wr_d   = 1'b0;
               rob_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_IF;
         cnt_q    <= '0;
         nbytes_q <= '0;
         rbuf_q   <= '0;
         wbuf_q   <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
         if_done  <= 1'b0;
         lsb_done <= 1'b0;
         rob_done <= 1'b0;
         if_data  <= '0;
         lsb_data <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         nbytes_q <= nbytes_d;
         rbuf_q   <= rbuf_d;
         wbuf_q   <= wbuf_d;
         mem_a    <= mem_a_d;
         mem_dout <= mem_dout_d;
         mem_wr   <= mem_wr_d;
         if_done  <= if_done_d;
         lsb_done <= lsb_done_d;
         rob_done <= rob_done_d;
         if_data  <= if_data_d;
         lsb_data <= lsb_data_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;

   localparam logic [31:0] IO_BASE = 32'h30000;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, io_buffer_full;
   logic        if_req, lsb_req, rob_req;
   logic [31:0] if_addr, lsb_addr, rob_addr, rob_data;
   logic [1:0]  lsb_size, rob_size;
   logic        if_done, lsb_done, rob_done, mem_wr;
   logic [31:0] if_data, lsb_data, mem_a;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;

   mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
      .lsb_done(lsb_done), .lsb_data(lsb_data),
      .rob_req(rob_req), .rob_addr(rob_addr), .rob_size(rob_size),
      .rob_data(rob_data), .rob_done(rob_done),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Sparse RAM; untouched bytes read back as an address-derived pattern.
   logic [7:0] ram [logic [31:0]];

   function automatic logic [7:0] ramrd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // The memory sits behind the same global enable as the rest of the system.
   always @(posedge clk) begin
      if (rdy) begin
         mem_din <= ramrd(mem_a);
         if (mem_wr) ram[mem_a] = mem_dout;
      end
   end

   // ---------------- timeline model ----------------
   typedef struct packed {
      logic [31:0] a;
      logic        ca;
      logic        wr;
      logic [7:0]  dout;
      logic        ifd;
      logic        lsbd;
      logic        robd;
      logic [31:0] data;
   } frame_t;

   frame_t      q[$];
   frame_t      cur = '0;
   logic        m_read = 1'b0;
   logic [31:0] e_if_data = '0, e_lsb_data = '0;

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   task automatic push_read(input logic [31:0] base, input logic [1:0] sz, input bit is_if);
      frame_t      f;
      logic [31:0] d = '0;
      for (int k = 0; k < nbytes(sz); k++) begin
         d[8*k +: 8] = ramrd(base + 32'(k));
         f = '0; f.a = base + 32'(k); f.ca = 1'b1;
         q.push_back(f);
      end
      f = '0;
      q.push_back(f);
      f = '0; f.data = d;
      if (is_if) f.ifd = 1'b1; else f.lsbd = 1'b1;
      q.push_back(f);
      m_read = 1'b1;
   endtask

   task automatic push_write(input logic [31:0] base, input logic [1:0] sz, input logic [31:0] data);
      frame_t f;
      for (int k = 0; k < nbytes(sz); k++) begin
         f = '0; f.a = base + 32'(k); f.ca = 1'b1; f.wr = 1'b1; f.dout = data[8*k +: 8];
         q.push_back(f);
      end
      f = '0; f.robd = 1'b1;
      q.push_back(f);
      m_read = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         cur = '0; m_read = 1'b0; e_if_data = '0; e_lsb_data = '0;
      end else begin
         chk("m_wr", mem_wr, cur.wr);
         if (cur.ca) chk("m_a", mem_a, cur.a);
         if (cur.wr) chk("m_dout", mem_dout, cur.dout);
         chk("m_if_done", if_done, cur.ifd);
         chk("m_lsb_done", lsb_done, cur.lsbd);
         chk("m_rob_done", rob_done, cur.robd);
         chk("m_if_data", if_data, e_if_data);
         chk("m_lsb_data", lsb_data, e_lsb_data);
         if (rdy) begin
            if (q.size() != 0) begin
               if (m_read && flush) q.delete();
            end else if (rob_req) begin
               if (!(rob_addr >= IO_BASE && io_buffer_full)) push_write(rob_addr, rob_size, rob_data);
            end else if (!flush) begin
               if (lsb_req) push_read(lsb_addr, lsb_size, 1'b0);
               else if (if_req) push_read(if_addr, 2'd2, 1'b1);
            end
            cur = (q.size() != 0) ? q.pop_front() : '0;
            if (cur.ifd)  e_if_data  = cur.data;
            if (cur.lsbd) e_lsb_data = cur.data;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rnd_addr(input bit io);
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFD + $urandom_range(0, 2);
         1:       return io ? IO_BASE + $urandom_range(0, 3) : 32'h2000 + $urandom_range(0, 15);
         default: return 32'h1000 + $urandom_range(0, 255);
      endcase
   endfunction

   initial begin
      int          at_rob, at_lsb, at_if, n_rob, n_lsb, n_if, nw, n_done;
      logic [31:0] w;
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; lsb_req = 1'b0; rob_req = 1'b0;
      if_addr = '0; lsb_addr = '0; rob_addr = '0; rob_data = '0;
      lsb_size = '0; rob_size = '0;
      cyc(3);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_dout", mem_dout, 32'h0);
      chk("rst_mem_wr", mem_wr, 32'h0);
      chk("rst_dones", {if_done, lsb_done, rob_done}, 32'h0);
      chk("rst_if_data", if_data, 32'h0);
      chk("rst_lsb_data", lsb_data, 32'h0);
      rst = 1'b1;

      // word fetch: 4 address cycles, done 6 cycles after request
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      if_addr = 32'h1000; if_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         cyc(1);
         if (c <= 4) chk("if_addr_cycle", mem_a, 32'h1000 + c - 1);
         chk("if_done_cycle", if_done, 32'(c == 6));
      end
      chk("if_data_word", if_data, 32'h0000_0013);
      if_req = 1'b0;

      // all three at once, issued in the fetch's done cycle
      rob_addr = 32'h200; rob_size = 2'd2; rob_data = 32'hDEADBEEF; rob_req = 1'b1;
      lsb_addr = 32'h1000; lsb_size = 2'd0; lsb_req = 1'b1;
      if_addr = 32'h1004; if_req = 1'b1;
      w = 32'hDEADBEEF;
      at_rob = 0; at_lsb = 0; at_if = 0; n_rob = 0; n_lsb = 0; n_if = 0;
      for (int c = 1; c <= 20; c++) begin
         cyc(1);
         if (c <= 4) begin
            chk("pri_wr", mem_wr, 32'h1);
            chk("pri_addr", mem_a, 32'h200 + c - 1);
            chk("pri_dout", mem_dout, w[8*(c-1) +: 8]);
         end
         if (rob_done) begin n_rob++; at_rob = c; rob_req = 1'b0; end
         if (lsb_done) begin n_lsb++; at_lsb = c; lsb_req = 1'b0; chk("pri_lsb_data", lsb_data, 32'h13); end
         if (if_done)  begin n_if++;  at_if = c;  if_req = 1'b0; end
      end
      chk("pri_rob_cycle", at_rob, 32'd5);
      chk("pri_lsb_cycle", at_lsb, 32'd8);
      chk("pri_if_cycle", at_if, 32'd14);
      chk("pri_done_counts", {8'(n_rob), 8'(n_lsb), 8'(n_if)}, 32'h010101);
      chk("pri_ram", {ramrd(32'h203), ramrd(32'h202), ramrd(32'h201), ramrd(32'h200)}, 32'hDEADBEEF);

      // misaligned halfword crossing a page-ish boundary
      ram[32'h1FFF] = 8'h80; ram[32'h2000] = 8'hFF;
      lsb_addr = 32'h1FFF; lsb_size = 2'd1; lsb_req = 1'b1; at_lsb = 0;
      for (int c = 1; c <= 6; c++) begin
         cyc(1);
         if (lsb_done && lsb_req) begin
            at_lsb = c; lsb_req = 1'b0;
            chk("lh_data", lsb_data, 32'h0000_FF80);
         end
      end
      chk("lh_cycle", at_lsb, 32'd4);

      // flush after byte 1 of a fetch is captured; a ROB store follows
      if_addr = 32'h1100; if_req = 1'b1; n_if = 0; at_rob = 0;
      cyc(4);
      flush = 1'b1; if_req = 1'b0;
      rob_addr = 32'h10; rob_size = 2'd0; rob_data = 32'h77; rob_req = 1'b1;
      for (int c = 5; c <= 10; c++) begin
         cyc(1);
         flush = 1'b0;
         if (if_done) n_if++;
         if (c == 6) begin
            chk("flush_rob_wr", mem_wr, 32'h1);
            chk("flush_rob_addr", mem_a, 32'h10);
            chk("flush_rob_dout", mem_dout, 32'h77);
         end
         if (rob_done && rob_req) begin at_rob = c; rob_req = 1'b0; end
      end
      chk("flush_no_if_done", n_if, 32'd0);
      chk("flush_rob_cycle", at_rob, 32'd7);

      // IO store held off by a full UART buffer; a load behind it also waits
      rob_addr = IO_BASE; rob_size = 2'd0; rob_data = 32'h41; rob_req = 1'b1; io_buffer_full = 1'b1;
      lsb_addr = 32'h1000; lsb_size = 2'd0; lsb_req = 1'b1;
      nw = 0; at_rob = 0; at_lsb = 0;
      for (int c = 1; c <= 14; c++) begin
         cyc(1);
         if (c <= 5) begin
            chk("io_stall_wr", mem_wr, 32'h0);
            chk("io_stall_lsb", lsb_done, 32'h0);
         end
         if (c == 5) io_buffer_full = 1'b0;
         if (c == 6) begin
            chk("io_addr", mem_a, IO_BASE);
            chk("io_dout", mem_dout, 32'h41);
         end
         if (mem_wr) nw++;
         if (rob_done && rob_req) begin at_rob = c; rob_req = 1'b0; end
         if (lsb_done && lsb_req) begin at_lsb = c; lsb_req = 1'b0; end
      end
      chk("io_write_count", nw, 32'd1);
      chk("io_rob_cycle", at_rob, 32'd7);
      chk("io_lsb_cycle", at_lsb, 32'd10);

      // rdy low for 3 cycles mid-fetch
      ram[32'h1200] = 8'h11; ram[32'h1201] = 8'h22; ram[32'h1202] = 8'h33; ram[32'h1203] = 8'h44;
      if_addr = 32'h1200; if_req = 1'b1; at_if = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc(1);
         rdy = !(c >= 3 && c <= 5);
         if (c >= 3 && c <= 6) chk("rdy_freeze_addr", mem_a, 32'h1202);
         if (c == 7) chk("rdy_resume_addr", mem_a, 32'h1203);
         if (if_done && if_req) begin
            at_if = c; if_req = 1'b0;
            chk("rdy_if_data", if_data, 32'h4433_2211);
         end
      end
      chk("rdy_if_cycle", at_if, 32'd9);

      // asynchronous reset in the middle of a word store
      rob_addr = 32'h300; rob_size = 2'd2; rob_data = 32'h0102_0304; rob_req = 1'b1;
      cyc(2);
      chk("arst_pre_wr", mem_wr, 32'h1);
      rst = 1'b0;
      #1;
      chk("arst_wr", mem_wr, 32'h0);
      chk("arst_addr", mem_a, 32'h0);
      rob_req = 1'b0;
      cyc(1);
      rst = 1'b1;

      // random traffic against the model
      n_done = 0;
      for (int t = 0; t < 4000; t++) begin
         cyc(1);
         if (if_req && if_done) begin
            if_req = 1'b0; n_done++;
         end else if (!if_req && !if_done && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = rnd_addr(1'b0);
         end
         if (lsb_req && lsb_done) begin
            lsb_req = 1'b0; n_done++;
         end else if (!lsb_req && !lsb_done && $urandom_range(0, 3) == 0) begin
            lsb_req = 1'b1; lsb_addr = rnd_addr(1'b0); lsb_size = 2'($urandom_range(0, 3));
         end
         if (rob_req && rob_done) begin
            rob_req = 1'b0; n_done++;
         end else if (!rob_req && !rob_done && $urandom_range(0, 4) == 0) begin
            rob_req = 1'b1; rob_addr = rnd_addr(1'b1);
            rob_size = 2'($urandom_range(0, 3)); rob_data = $urandom;
         end
         flush          = ($urandom_range(0, 11) == 0);
         rdy            = ($urandom_range(0, 7) != 0);
         io_buffer_full = ($urandom_range(0, 2) == 0);
      end
      if_req = 1'b0; lsb_req = 1'b0; rob_req = 1'b0;
      flush = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
      cyc(12);
      chk("random_progress", 32'(n_done > 100), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
